// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: ALU ops, operand-2 selects, branch kinds, MIPS opcode/funct values.
// Optional field decode_t.illegal exists only with DECODE_ILLEGAL_TRAP_EN.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_t;

    // Operand-2 select, shared with the EX operand-2 mux.
    localparam logic [1:0] ALU_SRC_REG   = 2'b00;
    localparam logic [1:0] ALU_SRC_SHAMT = 2'b01;
    localparam logic [1:0] ALU_SRC_SEXT  = 2'b10;
    localparam logic [1:0] ALU_SRC_ZEXT  = 2'b11;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg_addr;
        logic [1:0]  alu_srcs;
        logic [4:0]  sa;
        logic [15:0] immediate;
        alu_op_t     alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        jump;
        logic        link;
        logic        jr;
        logic [1:0]  branch;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } decode_t;

    function automatic decode_t decode_reset();
        decode_t d;
        d        = '0;
        d.alu_op = ALU_ADD;
        return d;
    endfunction

endpackage

// File: rtl/inst_decode_comb.sv
// rtl/inst_decode_comb.sv - combinational MIPS-subset decode table, instruction word to control bundle.
// Sets decode_t.illegal only with DECODE_ILLEGAL_TRAP_EN.
module inst_decode_comb
    import cpu_pkg::*;
(
    input  logic [31:0] inst,
    output decode_t     dec
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       known;
    logic       wr;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];

    always_comb begin
        dec           = decode_reset();
        dec.rs        = inst[25:21];
        dec.rt        = inst[20:16];
        dec.sa        = inst[10:6];
        dec.immediate = inst[15:0];
        dec.wreg_addr = (opcode == OP_RTYPE) ? inst[15:11] : inst[20:16];
        known         = 1'b1;
        wr            = 1'b0;

        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SLL:  begin dec.alu_op = ALU_SLL; dec.alu_srcs = ALU_SRC_SHAMT; wr = 1'b1; end
                FN_SRL:  begin dec.alu_op = ALU_SRL; dec.alu_srcs = ALU_SRC_SHAMT; wr = 1'b1; end
                FN_SRA:  begin dec.alu_op = ALU_SRA; dec.alu_srcs = ALU_SRC_SHAMT; wr = 1'b1; end
                FN_SLLV: begin dec.alu_op = ALU_SLL; wr = 1'b1; end
                FN_SRLV: begin dec.alu_op = ALU_SRL; wr = 1'b1; end
                FN_SRAV: begin dec.alu_op = ALU_SRA; wr = 1'b1; end
                FN_JR:   dec.jr = 1'b1;
                FN_ADD, FN_ADDU: begin dec.alu_op = ALU_ADD;  wr = 1'b1; end
                FN_SUB, FN_SUBU: begin dec.alu_op = ALU_SUB;  wr = 1'b1; end
                FN_AND:  begin dec.alu_op = ALU_AND;  wr = 1'b1; end
                FN_OR:   begin dec.alu_op = ALU_OR;   wr = 1'b1; end
                FN_XOR:  begin dec.alu_op = ALU_XOR;  wr = 1'b1; end
                FN_NOR:  begin dec.alu_op = ALU_NOR;  wr = 1'b1; end
                FN_SLT:  begin dec.alu_op = ALU_SLT;  wr = 1'b1; end
                FN_SLTU: begin dec.alu_op = ALU_SLTU; wr = 1'b1; end
                default: known = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU: begin dec.alu_op = ALU_ADD; dec.alu_srcs = ALU_SRC_SEXT; wr = 1'b1; end
                OP_SLTI:  begin dec.alu_op = ALU_SLT;  dec.alu_srcs = ALU_SRC_SEXT; wr = 1'b1; end
                OP_SLTIU: begin dec.alu_op = ALU_SLTU; dec.alu_srcs = ALU_SRC_SEXT; wr = 1'b1; end
                OP_LW: begin
                    dec.alu_op   = ALU_ADD;
                    dec.alu_srcs = ALU_SRC_SEXT;
                    dec.mem_read = 1'b1;
                    wr           = 1'b1;
                end
                OP_SW: begin
                    dec.alu_op    = ALU_ADD;
                    dec.alu_srcs  = ALU_SRC_SEXT;
                    dec.mem_write = 1'b1;
                end
                OP_ANDI: begin dec.alu_op = ALU_AND; dec.alu_srcs = ALU_SRC_ZEXT; wr = 1'b1; end
                OP_ORI:  begin dec.alu_op = ALU_OR;  dec.alu_srcs = ALU_SRC_ZEXT; wr = 1'b1; end
                OP_XORI: begin dec.alu_op = ALU_XOR; dec.alu_srcs = ALU_SRC_ZEXT; wr = 1'b1; end
                OP_LUI:  begin dec.alu_op = ALU_LUI; dec.alu_srcs = ALU_SRC_SEXT; wr = 1'b1; end
                OP_BEQ:  begin dec.alu_op = ALU_SUB; dec.branch = BR_EQ; end
                OP_BNE:  begin dec.alu_op = ALU_SUB; dec.branch = BR_NE; end
                OP_J:    dec.jump = 1'b1;
                OP_JAL: begin
                    dec.jump      = 1'b1;
                    dec.link      = 1'b1;
                    dec.wreg_addr = REG_RA;
                    wr            = 1'b1;
                end
                default: known = 1'b0;
            endcase
        end

        // $zero is never a real destination, so all-zero words fall out as NOPs.
        dec.reg_write = wr && (dec.wreg_addr != 5'd0);

        if (!known) begin
            dec.alu_op    = ALU_ADD;
            dec.alu_srcs  = ALU_SRC_REG;
            dec.reg_write = 1'b0;
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = !known;
`endif
    end

endmodule

// File: rtl/inst_decode.sv
// rtl/inst_decode.sv - ID stage: decodes fetched instruction into a one-entry registered bundle for EX.
// DECODE_ILLEGAL_TRAP_EN adds out_illegal flagging unlisted encodings.
module inst_decode
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      wreg_addr,
    output logic [1:0]      alu_srcs,
    output logic [4:0]      sa,
    output logic [15:0]     immediate,
    output alu_op_t         alu_op,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            jump,
    output logic            link,
    output logic            jr,
    output logic [1:0]      branch
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            out_illegal
`endif
);

    decode_t         dec;
    decode_t         bundle_q;
    logic            valid_q;
    logic [PC_W-1:0] pc_q;
    logic            accept;

    inst_decode_comb u_comb (
        .inst (in_inst),
        .dec  (dec)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            bundle_q <= decode_reset();
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            pc_q     <= in_pc;
            bundle_q <= dec;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign rs        = bundle_q.rs;
    assign rt        = bundle_q.rt;
    assign wreg_addr = bundle_q.wreg_addr;
    assign alu_srcs  = bundle_q.alu_srcs;
    assign sa        = bundle_q.sa;
    assign immediate = bundle_q.immediate;
    assign alu_op    = bundle_q.alu_op;
    assign reg_write = bundle_q.reg_write;
    assign mem_read  = bundle_q.mem_read;
    assign mem_write = bundle_q.mem_write;
    assign jump      = bundle_q.jump;
    assign link      = bundle_q.link;
    assign jr        = bundle_q.jr;
    assign branch    = bundle_q.branch;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign out_illegal = bundle_q.illegal;
`endif

endmodule
